// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - op encoding, FSM states and decode helpers for the RV64M multiply/divide unit
package ex_muldiv_pkg;

  localparam int MD_OP_W = 4;
  typedef logic [MD_OP_W-1:0] md_op_t;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Word-form high-half multiplies do not exist; fold them onto mul.
  function automatic logic [2:0] md_fix_f3(input md_op_t op);
    if (op[3] && !op[2]) return MD_MUL;
    return op[2:0];
  endfunction

  function automatic logic md_a_signed(input logic [2:0] f3);
    return (f3 == MD_MUL) || (f3 == MD_MULH) || (f3 == MD_MULHSU) ||
           (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

  function automatic logic md_b_signed(input logic [2:0] f3);
    return (f3 == MD_MUL) || (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// rtl/ex_muldiv_iter.sv - product / partial-remainder register with one shift-add or restoring-subtract step per cycle
module ex_muldiv_iter #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_div,
  input  logic              load_word,
  input  logic [XLEN-1:0]   mag_a,
  input  logic [XLEN-1:0]   mag_b,
  input  logic              step,
  output logic [2*XLEN-1:0] acc_next
);

  localparam int HALF = XLEN / 2;

  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic              div_mode;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic [XLEN:0]     div_diff;

  // Multiply: acc = {partial, multiplier}, shift right. Divide: acc = {rem, quo}, shift left.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    div_sh   = acc[2*XLEN-1:XLEN-1];
    div_diff = div_sh - {1'b0, opnd};
    if (div_mode) begin
      if (div_diff[XLEN]) acc_next = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else                acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      if (acc[0]) acc_next = {mul_sum, acc[XLEN-1:1]};
      else        acc_next = {1'b0, acc[2*XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      div_mode <= load_div;
      opnd     <= load_div ? mag_b : mag_a;
      // A word dividend starts at the top of the quotient half so HALF steps consume it.
      if (load_div) acc <= {{XLEN{1'b0}}, (load_word ? (mag_a << HALF) : mag_a)};
      else          acc <= {{XLEN{1'b0}}, mag_b};
    end else if (step) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// rtl/ex_muldiv_ctrl.sv - RV64M multiply/divide sequencer: handshake, FSM, fast paths and sign fix-up
module ex_muldiv_ctrl
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  md_op_t          md_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] md_res,
  output logic            busy
);

  localparam int HALF  = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_DWORD = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_WORD  = CNT_W'(HALF - 1);

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] v);
    return {{HALF{1'b0}}, v[HALF-1:0]};
  endfunction

  md_state_e         state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              accept, step, fin;
  logic              lat_word, lat_div, lat_rem, lat_hi, lat_neg;

  logic [2:0]        f3;
  logic              is_word, is_div, is_rem, a_sgn, b_sgn, s_a, s_b;
  logic              div_zero, div_ovf, fast;
  logic [XLEN-1:0]   ext_a, ext_b, mag_a, mag_b, min_neg, fast_res;

  logic [2*XLEN-1:0] acc_next, prod;
  logic [XLEN-1:0]   quo, rmd, calc_res;

  // Decode and fast-path detection on the extended operands, used only in the accept cycle.
  always_comb begin
    f3      = md_fix_f3(md_op);
    is_word = md_op[3];
    is_div  = f3[2];
    is_rem  = f3[2] & f3[1];
    a_sgn   = md_a_signed(f3);
    b_sgn   = md_b_signed(f3);
    ext_a   = is_word ? (a_sgn ? sext_w(rs1_data) : zext_w(rs1_data)) : rs1_data;
    ext_b   = is_word ? (b_sgn ? sext_w(rs2_data) : zext_w(rs2_data)) : rs2_data;
    s_a     = a_sgn & ext_a[XLEN-1];
    s_b     = b_sgn & ext_b[XLEN-1];
    mag_a   = s_a ? -ext_a : ext_a;
    mag_b   = s_b ? -ext_b : ext_b;
    min_neg = is_word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = is_div & (ext_b == '0);
    div_ovf  = is_div & ~f3[0] & (ext_a == min_neg) & (ext_b == '1);
    fast     = div_zero | div_ovf;
    if (div_zero) fast_res = is_rem ? ext_a : '1;
    else          fast_res = is_rem ? '0 : ext_a;
    if (is_word) fast_res = sext_w(fast_res);
  end

  // Final result from the value the last step is about to write.
  always_comb begin
    prod = lat_word ? (acc_next >> HALF) : acc_next;
    if (lat_neg) prod = -prod;
    quo = acc_next[XLEN-1:0];
    rmd = acc_next[2*XLEN-1:XLEN];
    if (lat_div) calc_res = lat_rem ? (lat_neg ? -rmd : rmd) : (lat_neg ? -quo : quo);
    else         calc_res = lat_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    if (lat_word) calc_res = sext_w(calc_res);
  end

  always_comb begin
    state_next = state;
    in_ready   = (state == MD_IDLE) & ~flush;
    accept     = in_ready & in_valid;
    step       = 1'b0;
    fin        = 1'b0;
    out_valid  = (state == MD_DONE);
    busy       = (state != MD_IDLE);
    case (state)
      MD_IDLE: if (accept) state_next = fast ? MD_DONE : MD_CALC;
      MD_CALC: begin
        step = 1'b1;
        if (cnt == '0) begin
          fin        = 1'b1;
          state_next = MD_DONE;
        end
      end
      MD_DONE: if (out_ready) state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
    if (flush) state_next = MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      md_res   <= '0;
      lat_word <= 1'b0;
      lat_div  <= 1'b0;
      lat_rem  <= 1'b0;
      lat_hi   <= 1'b0;
      lat_neg  <= 1'b0;
    end else begin
      if (accept) begin
        lat_word <= is_word;
        lat_div  <= is_div;
        lat_rem  <= is_rem;
        lat_hi   <= ~is_div & (f3 != MD_MUL);
        lat_neg  <= is_rem ? s_a : (s_a ^ s_b);
        cnt      <= is_word ? CNT_WORD : CNT_DWORD;
        if (fast) md_res <= fast_res;
      end else if (step) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (fin) md_res <= calc_res;
    end
  end

  ex_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept & ~fast),
    .load_div (is_div),
    .load_word(is_word),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .step     (step),
    .acc_next (acc_next)
  );

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb/tb_ex_muldiv_ctrl.sv - directed vector table plus handshake, flush and reset sequences for ex_muldiv_ctrl
module tb_ex_muldiv_ctrl;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      md_op = 4'd0;
  logic [XLEN-1:0] rs1_data = '0;
  logic [XLEN-1:0] rs2_data = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] md_res;
  logic            busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_muldiv_ctrl #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .md_op    (md_op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .md_res   (md_res),
    .busy     (busy)
  );

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    md_op    = op;
    rs1_data = a;
    rs2_data = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rs1_data = 64'hDEAD_BEEF_0BAD_F00D;
    rs2_data = 64'h0123_4567_89AB_CDEF;
  endtask

  // Latency counts the accept edge as 1; busy and ~in_ready must hold on every sample.
  task automatic wait_done(output int lat, output logic ok);
    lat = 1;
    ok  = busy & ~in_ready;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (!busy || in_ready) ok = 1'b0;
    end
  endtask

  task automatic consume(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_idle_busy"}, {63'd0, busy}, 64'd0);
    check({name, "_idle_ready"}, {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  int          lat;
  logic        ok;
  logic [63:0] held;

  initial begin
    vecs[0]  = '{4'd0,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{4'd1,  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 65};
    vecs[2]  = '{4'd4,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[3]  = '{4'd6,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[4]  = '{4'd13, 64'h1_0000_0064, 64'd10, 64'd10, 33};
    vecs[5]  = '{4'd5,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[6]  = '{4'd7,  64'd5, 64'd0, 64'd5, 1};
    vecs[7]  = '{4'd4,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[8]  = '{4'd12, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[9]  = '{4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[10] = '{4'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[11] = '{4'd8,  64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[12] = '{4'd14, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[13] = '{4'd5,  64'd100, 64'd7, 64'd14, 65};
    vecs[14] = '{4'd6,  64'd7, 64'd0, 64'd7, 1};
    vecs[15] = '{4'd14, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_md_res", md_res, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, ok);
      check($sformatf("v%0d_res", i), md_res, vecs[i].res);
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_busy", i), {63'd0, ok}, 64'd1);
      consume($sformatf("v%0d", i));
    end

    // Backpressure: result held for 10 cycles; an offered op in the release cycle is not taken.
    issue(4'd0, 64'd3, 64'd5);
    wait_done(lat, ok);
    held = md_res;
    check("bp_res", held, 64'd15);
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (md_res !== held || !out_valid || in_ready) ok = 1'b0;
    end
    check("bp_hold", {63'd0, ok}, 64'd1);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    md_op     = 4'd0;
    rs1_data  = 64'd2;
    rs2_data  = 64'd2;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_release_valid", {63'd0, out_valid}, 64'd0);
    check("bp_release_ready", {63'd0, in_ready}, 64'd1);
    check("bp_no_b2b_accept", {63'd0, busy}, 64'd0);

    // Flush at CALC cycle 20, with in_valid raised in the same cycle.
    issue(4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd9);
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("flush_calc_busy", {63'd0, busy}, 64'd0);
    check("flush_calc_valid", {63'd0, out_valid}, 64'd0);
    check("flush_idle_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("flush_no_accept", {63'd0, busy}, 64'd0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) ok = 1'b0;
    end
    check("flush_no_result", {63'd0, ok}, 64'd1);
    issue(4'd0, 64'd3, 64'd4);
    wait_done(lat, ok);
    check("after_flush_res", md_res, 64'd12);
    check("after_flush_lat", 64'(lat), 64'd65);

    // Flush together with out_ready in DONE still completes and returns to IDLE.
    @(negedge clk);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    check("flush_done_busy", {63'd0, busy}, 64'd0);
    check("flush_done_valid", {63'd0, out_valid}, 64'd0);

    // Reset in the middle of a divide.
    issue(4'd5, 64'd1000, 64'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstcalc_valid", {63'd0, out_valid}, 64'd0);
    check("rstcalc_busy", {63'd0, busy}, 64'd0);
    check("rstcalc_res", md_res, 64'd0);
    check("rstcalc_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) ok = 1'b0;
    end
    check("rstcalc_quiet", {63'd0, ok}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
